// File: rtl/seq_game_ctrl.sv
// Round controller for the memory-sequence game: shows the ROM sequence one element
// at a time, then checks user key presses against it until WIN or LOSE.
module seq_game_ctrl #(
    parameter int DISP_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int MAX_ROUND      = 15
) (
    input  logic       clk,
    input  logic       R,
    input  logic       start,
    input  logic       key_valid,
    input  logic [3:0] key,
    input  logic [3:0] rom_data,
    input  logic       tc_fpga,
    input  logic       tc_user,
    output logic       clr_fpga,
    output logic       clr_user,
    output logic       en_fpga,
    output logic       en_user,
    output logic       sel_user,
    output logic [3:0] round,
    output logic       show_en,
    output logic       win,
    output logic       lose,
    output logic [3:0] state
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_LOAD      = 4'd1;
    localparam logic [3:0] S_SHOW      = 4'd2;
    localparam logic [3:0] S_STEP      = 4'd3;
    localparam logic [3:0] S_CHK_F     = 4'd4;
    localparam logic [3:0] S_INPUT     = 4'd5;
    localparam logic [3:0] S_CHK_U     = 4'd6;
    localparam logic [3:0] S_ROUND_END = 4'd7;
    localparam logic [3:0] S_WIN       = 4'd8;
    localparam logic [3:0] S_LOSE      = 4'd9;

    localparam int DW = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    localparam logic [DW-1:0] DWELL_LAST = DW'(DISP_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    ROUND_LAST = 4'(MAX_ROUND);

    logic [3:0]    state_q, state_d;
    logic [3:0]    round_q, round_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          key_hit;

    assign key_hit = key_valid && (key == rom_data);

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        dwell_d = dwell_q;
        tmo_d   = tmo_q;
        case (state_q)
            S_IDLE, S_WIN, S_LOSE: begin
                if (start) begin
                    state_d = S_LOAD;
                    round_d = 4'd0;
                end
            end
            S_LOAD: begin
                state_d = S_SHOW;
                dwell_d = '0;
            end
            S_SHOW: begin
                if (dwell_q == DWELL_LAST) begin
                    state_d = S_STEP;
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            S_STEP: state_d = S_CHK_F;
            S_CHK_F: begin
                if (tc_fpga) begin
                    state_d = S_INPUT;
                    tmo_d   = '0;
                end else begin
                    state_d = S_SHOW;
                    dwell_d = '0;
                end
            end
            S_INPUT: begin
                // A key arriving on the last timeout cycle is still judged.
                if (key_valid) begin
                    state_d = key_hit ? S_CHK_U : S_LOSE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_LOSE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_CHK_U: begin
                if (tc_user) begin
                    state_d = S_ROUND_END;
                end else begin
                    state_d = S_INPUT;
                    tmo_d   = '0;
                end
            end
            S_ROUND_END: begin
                if (round_q == ROUND_LAST) begin
                    state_d = S_WIN;
                end else begin
                    state_d = S_LOAD;
                    round_d = round_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!R) begin
            state_q <= S_IDLE;
            round_q <= 4'd0;
            dwell_q <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            dwell_q <= dwell_d;
            tmo_q   <= tmo_d;
        end
    end

    // en_user is the one combinational path from inputs, so the user counter steps
    // in the same cycle the matching key is seen.
    always_comb begin
        clr_fpga = 1'b0;
        clr_user = 1'b0;
        en_fpga  = 1'b0;
        en_user  = 1'b0;
        sel_user = 1'b0;
        show_en  = 1'b0;
        win      = 1'b0;
        lose     = 1'b0;
        case (state_q)
            S_LOAD: begin
                clr_fpga = 1'b1;
                clr_user = 1'b1;
            end
            S_SHOW:  show_en = 1'b1;
            S_STEP:  en_fpga = 1'b1;
            S_INPUT: begin
                sel_user = 1'b1;
                en_user  = key_hit;
            end
            S_CHK_U: sel_user = 1'b1;
            S_WIN:   win  = 1'b1;
            S_LOSE:  lose = 1'b1;
            default: ;
        endcase
    end

    assign round = round_q;
    assign state = state_q;

endmodule

// File: tb/tb_seq_game_ctrl.sv
// Directed bench for seq_game_ctrl with behavioural address counters and a 4-entry ROM.
module tb_seq_game_ctrl;

    localparam int ST_IDLE = 0, ST_LOAD = 1, ST_SHOW = 2, ST_STEP = 3, ST_CHK_F = 4;
    localparam int ST_INPUT = 5, ST_CHK_U = 6, ST_RE = 7, ST_WIN = 8, ST_LOSE = 9;

    logic       clk = 1'b0;
    logic       R = 1'b0;
    logic       start = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key = 4'd0;
    logic [3:0] rom_data;
    logic       tc_fpga, tc_user;
    logic       clr_fpga, clr_user, en_fpga, en_user, sel_user, show_en, win, lose;
    logic [3:0] round, state;

    int total = 0;
    int bad = 0;

    seq_game_ctrl #(.DISP_CYCLES(4), .TIMEOUT_CYCLES(8), .MAX_ROUND(2)) dut (
        .clk(clk), .R(R), .start(start), .key_valid(key_valid), .key(key),
        .rom_data(rom_data), .tc_fpga(tc_fpga), .tc_user(tc_user),
        .clr_fpga(clr_fpga), .clr_user(clr_user), .en_fpga(en_fpga), .en_user(en_user),
        .sel_user(sel_user), .round(round), .show_en(show_en), .win(win), .lose(lose),
        .state(state)
    );

    always #5 clk = ~clk;

    // Counter + ROM models: tc goes sticky on the (round+1)-th enable.
    logic [3:0] rom [4] = '{4'd3, 4'd7, 4'd1, 4'd0};
    logic [4:0] cf = 5'd0, cu = 5'd0;
    logic       tcf = 1'b0, tcu = 1'b0;
    assign tc_fpga  = tcf;
    assign tc_user  = tcu;
    assign rom_data = sel_user ? rom[cu[1:0]] : rom[cf[1:0]];

    always @(posedge clk) begin
        if (clr_fpga) begin
            cf <= 5'd0; tcf <= 1'b0;
        end else if (en_fpga) begin
            cf <= cf + 5'd1;
            if (cf + 5'd1 == {1'b0, round} + 5'd1) tcf <= 1'b1;
        end
        if (clr_user) begin
            cu <= 5'd0; tcu <= 1'b0;
        end else if (en_user) begin
            cu <= cu + 5'd1;
            if (cu + 5'd1 == {1'b0, round} + 5'd1) tcu <= 1'b1;
        end
    end

    wire [7:0] outs = {clr_fpga, clr_user, en_fpga, en_user, sel_user, show_en, win, lose};

    typedef struct {
        logic       r_n;
        logic       st;
        logic       kv;
        logic [3:0] k;
        logic [3:0] e_state;
        logic [3:0] e_round;
        logic [7:0] e_outs;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic press(input logic [3:0] k, input logic exp_en);
        key_valid = 1'b1;
        key = k;
        #1;
        chk("en_user_on_key", en_user, exp_en);
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic to_input(output int shows, output int clrs);
        shows = 0;
        clrs = 0;
        for (int c = 0; c < 200; c++) begin
            if (state == 4'(ST_INPUT)) break;
            shows += int'(show_en);
            clrs  += int'(clr_fpga);
            step();
        end
        chk("reach_input", state, ST_INPUT);
    endtask

    initial begin
        int sh, cl, n;
        //            R  st kv key  state     round out
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 4'd0, 4'(ST_IDLE),  4'd0, 8'h00};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 4'd0, 4'(ST_IDLE),  4'd0, 8'h00};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 4'd0, 4'(ST_IDLE),  4'd0, 8'h00};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 4'd0, 4'(ST_IDLE),  4'd0, 8'h00};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 4'd0, 4'(ST_IDLE),  4'd0, 8'h00};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 4'd0, 4'(ST_LOAD),  4'd0, 8'hC0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 4'd0, 4'(ST_SHOW),  4'd0, 8'h04};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 4'd3, 4'(ST_SHOW),  4'd0, 8'h04};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 4'd0, 4'(ST_SHOW),  4'd0, 8'h04};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 4'd0, 4'(ST_SHOW),  4'd0, 8'h04};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 4'd0, 4'(ST_STEP),  4'd0, 8'h20};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 4'd0, 4'(ST_CHK_F), 4'd0, 8'h00};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 4'd0, 4'(ST_INPUT), 4'd0, 8'h08};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 4'd3, 4'(ST_INPUT), 4'd0, 8'h18};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 4'd0, 4'(ST_CHK_U), 4'd0, 8'h08};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 4'd0, 4'(ST_RE),    4'd0, 8'h00};

        R = 1'b0;
        step();
        for (int i = 0; i < 16; i++) begin
            R = tbl[i].r_n;
            start = tbl[i].st;
            key_valid = tbl[i].kv;
            key = tbl[i].k;
            #1;
            chk($sformatf("vec%0d_state", i), state, tbl[i].e_state);
            chk($sformatf("vec%0d_round", i), round, tbl[i].e_round);
            chk($sformatf("vec%0d_outs", i), outs, tbl[i].e_outs);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        key_valid = 1'b0;

        // Round 1 and 2 of a full game ending in WIN.
        chk("r1_load_state", state, ST_LOAD);
        chk("r1_round", round, 1);
        to_input(sh, cl);
        chk("r1_shows", sh, 8);
        chk("r1_clrs", cl, 1);
        press(4'd3, 1'b1);
        chk("r1_chku", state, ST_CHK_U);
        step();
        chk("r1_back_input", state, ST_INPUT);
        press(4'd7, 1'b1);
        step();
        chk("r1_round_end", state, ST_RE);
        step();
        chk("r2_load", state, ST_LOAD);
        chk("r2_round", round, 2);
        to_input(sh, cl);
        chk("r2_shows", sh, 12);
        chk("r2_clrs", cl, 1);
        press(4'd3, 1'b1);
        step();
        press(4'd7, 1'b1);
        step();
        press(4'd1, 1'b1);
        step();
        chk("r2_round_end", state, ST_RE);
        step();
        chk("win_state", state, ST_WIN);
        chk("win_out", win, 1);
        chk("win_round", round, 2);
        for (int i = 0; i < 3; i++) begin
            key_valid = 1'b1;
            step();
        end
        key_valid = 1'b0;
        chk("win_hold", win, 1);

        // Wrong key in round 1; start during INPUT is ignored.
        pulse_start();
        chk("wk_load", state, ST_LOAD);
        chk("wk_round0", round, 0);
        to_input(sh, cl);
        press(4'd3, 1'b1);
        to_input(sh, cl);
        chk("wk_round1", round, 1);
        press(4'd3, 1'b1);
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_in_input_state", state, ST_INPUT);
        chk("start_in_input_round", round, 1);
        press(4'd4, 1'b0);
        chk("wk_lose_state", state, ST_LOSE);
        chk("wk_lose_out", lose, 1);
        chk("wk_lose_round", round, 1);
        pulse_start();
        chk("restart_state", state, ST_LOAD);
        chk("restart_round", round, 0);

        // Timeout with no key.
        to_input(sh, cl);
        n = 0;
        while (state == 4'(ST_INPUT) && n < 20) begin
            step();
            n++;
        end
        chk("tmo_cycles", n, 8);
        chk("tmo_lose", lose, 1);

        // Correct key on the final timeout cycle wins over timeout.
        pulse_start();
        to_input(sh, cl);
        repeat (7) step();
        chk("tmo_last_still_input", state, ST_INPUT);
        press(4'd3, 1'b1);
        chk("tmo_key_chku", state, ST_CHK_U);

        // Reset mid-INPUT and mid-SHOW.
        to_input(sh, cl);
        R = 1'b0;
        step();
        R = 1'b1;
        chk("rst_input_state", state, ST_IDLE);
        chk("rst_input_round", round, 0);
        chk("rst_input_outs", outs, 0);
        pulse_start();
        step();
        chk("pre_rst_show", state, ST_SHOW);
        R = 1'b0;
        step();
        R = 1'b1;
        chk("rst_show_state", state, ST_IDLE);
        chk("rst_show_outs", outs, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
